// File: rtl/fifo_stream_pkg.sv
// ---------------------------------------------------------------------------
// fifo_stream_pkg
//
// Shared definitions for the FIFO-to-stream reader:
//   SKID_DEPTH  - number of words the skid buffer can hold
//   buf_cnt_t   - occupancy count of the skid buffer (0..SKID_DEPTH)
//   occupancy() - buffered words plus the word still in flight from the FIFO
// ---------------------------------------------------------------------------
package fifo_stream_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

    // Everything the reader has claimed: what sits in the buffer plus the
    // word requested last cycle that is returning on fifo_q_i this cycle.
    function automatic logic [2:0] occupancy(input buf_cnt_t cnt, input logic inflight);
        return {1'b0, cnt} + {2'b00, inflight};
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
//
// Two-entry in-order buffer between the FIFO read port and the stream
// output. Entry slot0 is always the head, so rdata needs no read mux.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset, empties and zeroes the buffer
//   clr    - synchronous discard of all buffered words
//   wr     - write wdata at the tail this cycle
//   wdata  - word to write
//   rd     - remove the head entry this cycle
//   rdata  - head entry
//   cnt    - number of valid entries (0..2)
// ---------------------------------------------------------------------------
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 8
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd,
    output logic [DWIDTH-1:0] rdata,
    output logic [1:0]        cnt
);

    localparam buf_cnt_t FULL = buf_cnt_t'(SKID_DEPTH);

    logic [DWIDTH-1:0] slot0_q, slot1_q;
    logic [DWIDTH-1:0] slot0_n, slot1_n;
    buf_cnt_t          cnt_q, cnt_n;
    logic              rd_ok, wr_ok;

    // A read of an empty buffer is ignored, and a write into a full buffer
    // is only accepted when the head leaves in the same cycle, so the
    // buffer can never overflow even if the caller misbehaves.
    assign rd_ok = rd && (cnt_q != '0);
    assign wr_ok = wr && ((cnt_q != FULL) || rd_ok);

    // Next-state: slot0 is the head. A pop shifts slot1 forward; a write
    // lands in the first free slot after any shift, which keeps order.
    always_comb begin
        slot0_n = slot0_q;
        slot1_n = slot1_q;
        cnt_n   = cnt_q;
        if (clr) begin
            cnt_n = '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10: begin
                    if (cnt_q == '0) begin
                        slot0_n = wdata;
                    end else begin
                        slot1_n = wdata;
                    end
                    cnt_n = cnt_q + 2'd1;
                end
                2'b01: begin
                    slot0_n = slot1_q;
                    cnt_n   = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        slot0_n = wdata;
                    end else begin
                        slot0_n = slot1_q;
                        slot1_n = wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            slot0_q <= slot0_n;
            slot1_q <= slot1_n;
            cnt_q   <= cnt_n;
        end
    end

    assign rdata = slot0_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Turns a SHOWAHEAD="OFF" FIFO read port (data one cycle after rdreq) into a
// valid/ready stream. A two-entry skid buffer absorbs the read latency so the
// stream runs at one word per cycle while ready_i stays high, and valid_o /
// data_o come straight from registers (no combinational path from ready_i).
//
// Ports:
//   clk_i         - clock, rising edge
//   rst_i         - asynchronous active-high reset
//   fifo_rdreq_o  - read request to the FIFO (combinational)
//   fifo_q_i      - FIFO read data, valid one cycle after fifo_rdreq_o
//   fifo_empty_i  - FIFO empty flag
//   fifo_usedw_i  - FIFO fill level
//   valid_o       - stream word available
//   data_o        - stream word (head of the skid buffer)
//   ready_i       - sink accepts the word
//   flush_i       - discard buffered and in-flight words
//   level_o       - unregistered copy of fifo_usedw_i
//   xfer_cnt_o    - number of completed stream transfers, wraps
// ---------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int CWIDTH = 16
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              fifo_rdreq_o,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH-1:0] fifo_usedw_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o,
    input  logic              ready_i,
    input  logic              flush_i,
    output logic [AWIDTH-1:0] level_o,
    output logic [CWIDTH-1:0] xfer_cnt_o
);

    buf_cnt_t          buf_cnt;
    logic              inflight;
    logic              armed;
    logic              pop;
    logic              buf_wr;
    logic [2:0]        occ;
    logic [2:0]        occ_after_pop;
    logic [CWIDTH-1:0] xfer_cnt_q;
    logic [1:0]        skid_cnt;

    // A transfer happens on valid && ready; a flush cancels it so the word
    // is discarded rather than counted as delivered.
    assign pop = valid_o && ready_i && !flush_i;

    // The returning word is written unless a flush throws it away.
    assign buf_wr = inflight && !flush_i;

    // Credit check: after this cycle's pop, everything already claimed
    // (buffered + in flight) must leave room for one more word.
    assign occ           = occupancy(buf_cnt, inflight);
    assign occ_after_pop = occ - {2'b00, pop};

    // 'armed' is cleared by reset and set on the first edge afterwards, so
    // no request can appear between reset release and that edge, and the
    // request is forced low asynchronously while reset is held.
    assign fifo_rdreq_o = armed && !fifo_empty_i && !flush_i &&
                          (occ_after_pop < 3'(SKID_DEPTH));

    stream_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (flush_i),
        .wr     (buf_wr),
        .wdata  (fifo_q_i),
        .rd     (pop),
        .rdata  (data_o),
        .cnt    (skid_cnt)
    );

    assign buf_cnt = buf_cnt_t'(skid_cnt);
    assign valid_o = (buf_cnt != '0);

    // Request tracking and transfer counting. inflight mirrors last cycle's
    // request, which is exactly when fifo_q_i carries the requested word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed      <= 1'b0;
            inflight   <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            armed    <= 1'b1;
            inflight <= fifo_rdreq_o;
            if (pop) begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
            end
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
    assign level_o    = fifo_usedw_i;

endmodule
